mdu_unit: RTL

//  Parametrised multi-cycle multiply/divide unit in the EX stage, beside the ALU.

---
 rtl/mdu_pkg.sv | 39 +++
 rtl/mdu_arith.sv | 84 ++++++++
 rtl/mdu_unit.sv | 136 +++++++++++++
 3 files changed

// File: rtl/mdu_pkg.sv
// ============================================================================
// Module      : mdu_pkg
// Description : Op codes, FSM states and default latencies for the MDU.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

package mdu_pkg;

  localparam int OP_W        = 4;
  localparam int MUL_LAT_DEF = 5;
  localparam int DIV_LAT_DEF = 10;

  // mdu_op is 4 bits wide so that MTLO gets a code of its own.
  typedef enum logic [OP_W-1:0] {
    NOP   = 4'd0,
    MULT  = 4'd1,
    MULTU = 4'd2,
    DIV   = 4'd3,
    DIVU  = 4'd4,
    MFHI  = 4'd5,
    MFLO  = 4'd6,
    MTHI  = 4'd7,
    MTLO  = 4'd8
  } mdu_op_e;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } mdu_state_e;

  function automatic logic is_mul(input mdu_op_e op);
    return (op == MULT) || (op == MULTU);
  endfunction

endpackage

`default_nettype wire

// File: rtl/mdu_arith.sv
// ============================================================================
// Module      : mdu_arith
// Description : Combinational multiply/divide datapath producing {hi, lo}.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdu_arith
  import mdu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  input  mdu_op_e          op_i,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam logic [WIDTH-1:0] c_ALL_ONES = '1;
  localparam logic [WIDTH-1:0] c_MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  logic                 w_sext;
  logic [2*WIDTH-1:0]   w_a_ext;
  logic [2*WIDTH-1:0]   w_b_ext;
  logic [2*WIDTH-1:0]   w_prod;
  logic [WIDTH-1:0]     w_sq;
  logic [WIDTH-1:0]     w_sr;
  logic [WIDTH-1:0]     w_uq;
  logic [WIDTH-1:0]     w_ur;
  logic                 w_b_zero;
  logic                 w_ovf;

  // Low 2*WIDTH bits of the extended unsigned product equal the signed product.
  assign w_sext  = (op_i == MULT);
  assign w_a_ext = w_sext ? {{WIDTH{a_i[WIDTH-1]}}, a_i} : {{WIDTH{1'b0}}, a_i};
  assign w_b_ext = w_sext ? {{WIDTH{b_i[WIDTH-1]}}, b_i} : {{WIDTH{1'b0}}, b_i};
  assign w_prod  = w_a_ext * w_b_ext;

  assign w_sq = $signed(a_i) / $signed(b_i);
  assign w_sr = $signed(a_i) % $signed(b_i);
  assign w_uq = a_i / b_i;
  assign w_ur = a_i % b_i;

  assign w_b_zero = (b_i == '0);
  assign w_ovf    = (a_i == c_MOST_NEG) && (b_i == c_ALL_ONES);

  always_comb begin
    hi_o = '0;
    lo_o = '0;
    case (op_i)
      MULT, MULTU: {hi_o, lo_o} = w_prod;
      DIV: begin
        if (w_b_zero) begin
          hi_o = a_i;
          lo_o = c_ALL_ONES;
        end else if (w_ovf) begin
          hi_o = '0;
          lo_o = a_i;
        end else begin
          hi_o = w_sr;
          lo_o = w_sq;
        end
      end
      DIVU: begin
        if (w_b_zero) begin
          hi_o = a_i;
          lo_o = c_ALL_ONES;
        end else begin
          hi_o = w_ur;
          lo_o = w_uq;
        end
      end
      default: begin
        hi_o = '0;
        lo_o = '0;
      end
    endcase
  end

endmodule

`default_nettype wire

// File: rtl/mdu_unit.sv
// ============================================================================
// Module      : mdu_unit
// Description : Multi-cycle multiply/divide unit owning the HI/LO registers.
// Revision    : 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module mdu_unit
  import mdu_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = MUL_LAT_DEF,
  parameter int DIV_LAT = DIV_LAT_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [OP_W-1:0]  mdu_op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic [WIDTH-1:0] HI,
  output logic [WIDTH-1:0] LO,
  output logic [WIDTH-1:0] rd_data
);

  localparam int c_MAX_LAT = (MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT;
  localparam int c_CNT_W   = $clog2(c_MAX_LAT + 1);
  localparam logic [c_CNT_W-1:0] c_MUL_CNT = c_CNT_W'(MUL_LAT);
  localparam logic [c_CNT_W-1:0] c_DIV_CNT = c_CNT_W'(DIV_LAT);
  localparam logic [c_CNT_W-1:0] c_CNT_ONE = c_CNT_W'(1);

  mdu_state_e         state_q, state_d;
  logic [c_CNT_W-1:0] cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  mdu_op_e            op_q, op_d;
  logic [WIDTH-1:0]   hi_q, hi_d;
  logic [WIDTH-1:0]   lo_q, lo_d;

  mdu_op_e            w_op;
  logic [WIDTH-1:0]   w_res_hi;
  logic [WIDTH-1:0]   w_res_lo;

  assign w_op = mdu_op_e'(mdu_op);

  // Result is derived only from the captured operands, so A/B may change during RUN.
  mdu_arith #(
    .WIDTH (WIDTH)
  ) u_arith (
    .a_i  (a_q),
    .b_i  (b_q),
    .op_i (op_q),
    .hi_o (w_res_hi),
    .lo_o (w_res_lo)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      a_q     <= '0;
      b_q     <= '0;
      op_q    <= NOP;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      busy_q  <= busy_d;
      a_q     <= a_d;
      b_q     <= b_d;
      op_q    <= op_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    a_d     = a_q;
    b_d     = b_q;
    op_d    = op_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          case (w_op)
            MULT, MULTU, DIV, DIVU: begin
              state_d = S_RUN;
              a_d     = A;
              b_d     = B;
              op_d    = w_op;
              cnt_d   = is_mul(w_op) ? c_MUL_CNT : c_DIV_CNT;
            end
            MTHI:    hi_d = A;
            MTLO:    lo_d = A;
            default: ;
          endcase
        end
      end
      S_RUN: begin
        // Any start seen here is dropped; the hazard unit keeps it from happening.
        cnt_d = cnt_q - c_CNT_ONE;
        if (cnt_q == c_CNT_ONE) begin
          state_d = S_IDLE;
          hi_d    = w_res_hi;
          lo_d    = w_res_lo;
        end
      end
      default: state_d = S_IDLE;
    endcase
    busy_d = (state_d == S_RUN);
  end

  always_comb begin
    rd_data = '0;
    if (w_op == MFHI) begin
      rd_data = hi_q;
    end else if (w_op == MFLO) begin
      rd_data = lo_q;
    end
  end

  assign busy = busy_q;
  assign HI   = hi_q;
  assign LO   = lo_q;

endmodule

`default_nettype wire
